fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the model computer. Sits directly downstream of the 256×8 program RAM. It owns the program counter, drives the RAM `read`/`address` inputs, and captures the RAM `out` byte one cycle later. Fetched bytes are buffered in a small FIFO and handed to the decoder over a valid/ready handshake; a jump input redirects the PC and flushes everything in flight.

## Interface
- `ADDR_W`, 8: PC and RAM address width.
- `DATA_W`, 8: instruction byte width.
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `HALT_OP`, 8'hF0: halt opcode. Used only with `FETCH_HALT_DETECT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `run`  in  1  fetch enable; 0 stops new reads.
- `jump`  in  1  one-cycle redirect strobe.
- `jump_addr`  in  ADDR_W  redirect target.
- `ram_read`  out  1  read strobe to the RAM `read` input.
- `ram_address`  out  ADDR_W  to the RAM `address` input; always equal to `pc`.
- `ram_out`  in  DATA_W  RAM `out`; valid the cycle after `ram_read`.
- `instr`  out  DATA_W  FIFO head byte.
- `instr_pc`  out  ADDR_W  address of the head byte.
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  decoder accepts the head.
- `pc`  out  ADDR_W  next fetch address.
- `halted`  out  1  halt opcode fetched.

## Operation
- State machine:
  - IDLE: `run`=0.
  - FETCH: `run`=1 and not halted.
  - HALT: halt opcode seen.
  - Transitions:
    - IDLE→FETCH on `run`=1. FETCH→IDLE on `run`=0.
    - FETCH→HALT on a push of `HALT_OP` (macro only).
    - HALT→FETCH (or IDLE if `run`=0) on `jump`. Any state→IDLE on reset.
- Pop: `pop = instr_valid & instr_ready`.
- Issue condition: `ram_read = FETCH & ~jump & (count + req_q − pop < DEPTH)`.
  - `count` is the FIFO occupancy.
  - `req_q` flags a read issued last cycle.
  - `ram_read` is combinational from registers and inputs.
- On issue: `pc` ← `pc`+1, modulo 2^ADDR_W (255→0 wraps silently). `req_q`←1, `req_pc`←`pc`. Otherwise `req_q`←0.
- Capture: in a cycle with `req_q`=1, push {`ram_out`, `req_pc`} into the FIFO.
- FIFO:
  - Push and pop in the same cycle is legal; `count` is unchanged.
  - The issue condition guarantees no overflow. Pop when empty cannot occur.
  - FIFO order is strict program order.
- Jump (highest priority):
  - `pc`←`jump_addr`.
  - FIFO cleared, `count`←0.
  - `req_q`←0; the byte returning this cycle is discarded.
  - `halted`←0. No read is issued that cycle.
  - A pop coinciding with `jump` counts as consumed by the decoder.
- `run` falling: no new issues. An in-flight byte is still captured. The FIFO contents remain poppable.

## Timing
- Reset values: `pc`=0, `ram_read`=0, `ram_address`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0, `count`=0, `req_q`=0.
- Read latency: read issued in cycle N, byte pushed at the end of N+1, `instr_valid` high in N+2.
- Jump latency: `jump` in cycle J, read of `jump_addr` in J+1, first post-jump `instr_valid` in J+3.
- Throughput: 1 byte/cycle sustained while `instr_ready`=1.
- `instr`/`instr_pc` are don't-care while `instr_valid`=0.
- Reset mid-operation: all state clears immediately (asynchronous). A RAM byte arriving after release is ignored because `req_q`=0.
- Handshake: `instr`, `instr_pc` and `instr_valid` stay stable until popped or flushed by `jump`.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - A push of `HALT_OP` sets `halted`=1 at that edge.
  - Further issues are blocked until `jump` or reset.
  - The halt byte itself is delivered through the FIFO.
- `FETCH_HALT_DETECT_EN` undefined: `halted` is tied 0, `HALT_OP` is ignored, and fetch runs until `run`=0.

## Test plan
- Reset then `run`=1 with RAM[0..3]=11,22,33,44 and `instr_ready`=1 → `instr`=11,22,33,44 with `instr_pc`=0..3 on consecutive cycles. First valid is 2 cycles after the first `ram_read`.
- `instr_ready`=0, `run`=1 → exactly `DEPTH`=4 reads issued, then `ram_read`=0. Release `instr_ready` → bytes delivered in order, no loss or duplicates.
- `jump`=1 with `jump_addr`=8'h80 while the FIFO holds 3 entries and one read is in flight → `instr_valid`=0 next cycle. `ram_read` with address 0x80 next cycle. First delivered `instr_pc`=0x80.
- Start at `pc`=8'hFE → `instr_pc` sequence FE, FF, 00, 01.
- With macro defined, RAM[2]=F0 → bytes 0..2 delivered, `halted`=1, no read of address 4 or beyond. `jump` to 0 → `halted`=0 and fetch resumes. Without macro, same stimulus → fetch continues past address 2.
- `rst` asserted mid-stream with the FIFO full → all outputs at reset values immediately. After release, fetch restarts from address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the program RAM, buffers bytes in a small FIFO.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter logic [DATA_W-1:0] HALT_OP = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t               state, state_nxt;
  entry_t [DEPTH-1:0]   mem;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 req_q;
  logic [ADDR_W-1:0]    req_pc, pc_q;
  logic                 pop, push, halt_hit;
  logic [CW:0]          occ;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A byte returning in the jump cycle belongs to the old stream and is dropped.
  assign push        = req_q & ~jump;
  assign halt_hit    = push & (ram_out == HALT_OP);

  // Occupancy after this cycle's in-flight byte lands, counting the pop.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, req_q} - {{CW{1'b0}}, pop};
  assign ram_read = (state == FETCH) & ~jump & (occ < DEPTH_C);

  assign pc          = pc_q;
  assign ram_address = pc_q;
  assign instr       = mem[rd_ptr].data;
  assign instr_pc    = mem[rd_ptr].pc;
  assign halted      = HALT_EN & (state == HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH: begin
        if (HALT_EN && halt_hit) state_nxt = HALT;
        else if (!run)           state_nxt = IDLE;
      end
      HALT:    if (jump) state_nxt = run ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc_q   <= '0;
      req_q  <= 1'b0;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      state <= state_nxt;
      req_q <= ram_read;
      if (jump)          pc_q <= jump_addr;
      else if (ram_read) pc_q <= pc_q + ADDR_W'(1);
      if (ram_read)      req_pc <= pc_q;

      if (jump) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= '{data: ram_out, pc: req_pc};
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: RAM model, expected-byte scoreboard, negedge monitor.
module tb_fetch_unit;
  logic       clk = 1'b0, rst = 1'b0, run = 1'b0, jump = 1'b0, instr_ready = 1'b0;
  logic [7:0] jump_addr = '0, ram_out = '0;
  logic [7:0] ram_address, instr, instr_pc, pc;
  logic       ram_read, instr_valid, halted;

  logic [7:0]  ram [256];
  logic [15:0] exp_q[$];
  logic [15:0] e;
  int          pcyc[$];
  int nchk = 0, nerr = 0, cyc = 0, nreads = 0, rd_first = -1, v_first = -1, last_addr = 0, jc = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .run(run), .jump(jump), .jump_addr(jump_addr),
    .ram_read(ram_read), .ram_address(ram_address), .ram_out(ram_out),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    cyc++;
    if (ram_read) ram_out <= ram[ram_address];
  end

  always @(negedge clk) if (rst) begin
    if (ram_read) begin
      nreads++;
      last_addr = int'(ram_address);
      if (rd_first < 0) rd_first = cyc;
    end
    if (instr_valid && v_first < 0) v_first = cyc;
    if (instr_valid && instr_ready) begin
      pcyc.push_back(cyc);
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL pop: got instr=%h pc=%h, nothing expected", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          nerr++;
          $display("FAIL pop: got instr=%h pc=%h, expected instr=%h pc=%h",
                   instr, instr_pc, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_rng(input logic [7:0] start, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      exp_q.push_back({ram[a], a});
    end
  endtask

  task automatic clr();
    nreads = 0; rd_first = -1; v_first = -1;
    pcyc.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},          32'(pc), 0);
    chk({tag, "_ram_read"},    32'(ram_read), 0);
    chk({tag, "_ram_address"}, 32'(ram_address), 0);
    chk({tag, "_instr"},       32'(instr), 0);
    chk({tag, "_instr_pc"},    32'(instr_pc), 0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
    chk({tag, "_halted"},      32'(halted), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h35;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    tick(2);
    chk_reset("rst");
    rst = 1'b1;
    tick(1);

    // Streaming from address 0 with the decoder always ready
    clr();
    instr_ready = 1'b1;
    expect_rng(8'h00, 4);
    run = 1'b1;
    tick(4);
    run = 1'b0;
    tick(6);
    chk("t1_reads", 32'(nreads), 4);
    chk("t1_latency", 32'(v_first - rd_first), 2);
    chk("t1_pops", 32'(pcyc.size()), 4);
    if (pcyc.size() == 4) chk("t1_pop_span", 32'(pcyc[3] - pcyc[0]), 3);
    chk("t1_drain", 32'(exp_q.size()), 0);
    chk("t1_pc", 32'(pc), 4);

    // Backpressure: FIFO fills to DEPTH, head held stable
    clr();
    instr_ready = 1'b0;
    expect_rng(8'h04, 4);
    run = 1'b1;
    tick(10);
    chk("t2_reads", 32'(nreads), 4);
    chk("t2_ram_read", 32'(ram_read), 0);
    chk("t2_valid", 32'(instr_valid), 1);
    chk("t2_head_pc", 32'(instr_pc), 4);
    chk("t2_head", 32'(instr), 32'(ram[4]));
    run = 1'b0;
    tick(2);
    instr_ready = 1'b1;
    tick(8);
    chk("t2_drain", 32'(exp_q.size()), 0);
    chk("t2_reads_after", 32'(nreads), 4);

    // Jump with 3 bytes buffered and one in flight
    clr();
    instr_ready = 1'b0;
    run = 1'b1;
    tick(5);
    chk("t3_pre_reads", 32'(nreads), 4);
    chk("t3_pre_head", 32'(instr_pc), 8);
    jump = 1'b1; jump_addr = 8'h80; jc = cyc;
    #1 chk("t3_jump_noread", 32'(ram_read), 0);
    tick(1);
    jump = 1'b0; run = 1'b0; instr_ready = 1'b1; v_first = -1;
    #1;
    chk("t3_flush", 32'(instr_valid), 0);
    chk("t3_read", 32'(ram_read), 1);
    chk("t3_addr", 32'(ram_address), 32'h80);
    expect_rng(8'h80, 1);
    tick(8);
    chk("t3_latency", 32'(v_first - jc), 3);
    chk("t3_drain", 32'(exp_q.size()), 0);

    // PC wrap FE, FF, 00, 01
    clr();
    jump = 1'b1; jump_addr = 8'hFE;
    tick(1);
    jump = 1'b0;
    chk("t4_pc", 32'(pc), 32'hFE);
    expect_rng(8'hFE, 4);
    run = 1'b1;
    tick(4);
    run = 1'b0;
    tick(6);
    chk("t4_reads", 32'(nreads), 4);
    chk("t4_drain", 32'(exp_q.size()), 0);
    chk("t4_pc_end", 32'(pc), 2);

    // Halt opcode at address 2
    ram[2] = 8'hF0;
    clr();
    jump = 1'b1; jump_addr = 8'h00;
    tick(1);
    jump = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    expect_rng(8'h00, 4);
    run = 1'b1;
    tick(6);
    run = 1'b0;
    tick(4);
    chk("t5_halted", 32'(halted), 1);
    chk("t5_reads", 32'(nreads), 4);
    chk("t5_last_addr", 32'(last_addr), 3);
    chk("t5_drain", 32'(exp_q.size()), 0);
    run = 1'b1; jump = 1'b1; jump_addr = 8'h00;
    #1 chk("t5_jump_noread", 32'(ram_read), 0);
    tick(1);
    jump = 1'b0; run = 1'b0;
    #1;
    chk("t5_unhalt", 32'(halted), 0);
    chk("t5_resume", 32'(ram_read), 1);
    chk("t5_resume_addr", 32'(ram_address), 0);
    expect_rng(8'h00, 1);
    tick(6);
    chk("t5_drain2", 32'(exp_q.size()), 0);
`else
    expect_rng(8'h00, 6);
    run = 1'b1;
    tick(6);
    run = 1'b0;
    tick(6);
    chk("t5_halted", 32'(halted), 0);
    chk("t5_reads", 32'(nreads), 6);
    chk("t5_last_addr", 32'(last_addr), 5);
    chk("t5_drain", 32'(exp_q.size()), 0);
`endif
    ram[2] = 8'h33;

    // Asynchronous reset with a full FIFO, then restart from 0
    clr();
    instr_ready = 1'b0;
    jump = 1'b1; jump_addr = 8'h40;
    tick(1);
    jump = 1'b0;
    run = 1'b1;
    tick(8);
    chk("t6_full_valid", 32'(instr_valid), 1);
    chk("t6_full_reads", 32'(nreads), 4);
    #2 rst = 1'b0;
    #1 chk_reset("t6");
    run = 1'b0; instr_ready = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("t6_pc_restart", 32'(pc), 0);
    clr();
    expect_rng(8'h00, 4);
    run = 1'b1;
    tick(4);
    run = 1'b0;
    tick(6);
    chk("t6_reads", 32'(nreads), 4);
    chk("t6_drain", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
